fft_iter_bf_sequencer: RTL and testbench
========================================

Name: fft_iter_bf_sequencer

Overview:
- Control and operand-staging stage directly upstream of the radix-2 complex butterfly in the iterative in-place FFT.
- Walks all stages and butterflies of a P = 2^LOG2_PTS point DIT FFT, issuing dual-port data RAM reads and twiddle ROM reads.
- Registers the returned operands onto the butterfly inputs, then registers the butterfly results back to the RAM write port with matching addresses.
- Input data sits in the RAM in bit-reversed order; output is natural order, in place.

Parameters:
- N, 16, data and twiddle width (Q1.(N-1) two's complement)
- LOG2_PTS, 4, log2 of FFT length P; legal range 2..12

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request, sampled in IDLE only
- o_busy  out  1  high from first issue cycle through last write cycle
- o_done  out  1  one-cycle pulse after final write
- o_stage  out  log2(LOG2_PTS)+1  current stage index 0..LOG2_PTS-1
- o_rd_en  out  1  RAM/ROM read strobe
- o_rd_addr_a, o_rd_addr_b  out  LOG2_PTS  RAM read addresses
- o_tw_addr  out  LOG2_PTS-1  twiddle ROM index j (ROM holds W^j = e^(-i2πj/P), Q1.(N-1))
- i_rd_Are, i_rd_Aim, i_rd_Bre, i_rd_Bim  in  N  RAM read data, valid 1 cycle after o_rd_en
- i_Wre, i_Wim  in  N  ROM data, valid 1 cycle after o_rd_en
- o_Are, o_Aim, o_Bre, o_Bim, o_Wre, o_Wim  out  N  registered butterfly operands
- o_bf_valid  out  1  butterfly operands valid
- i_X_re, i_X_im, i_Y_re, i_Y_im  in  N  butterfly results (combinational from o_* operands)
- o_wr_en  out  1  RAM write strobe
- o_wr_addr_a, o_wr_addr_b  out  LOG2_PTS  write addresses (X to a, Y to b)
- o_wr_X_re, o_wr_X_im, o_wr_Y_re, o_wr_Y_im  out  N  write data

Behaviour:
- Reset (async, any time including mid-run): state IDLE, all counters 0, every output 0; pipeline valids cleared, so no write is ever issued after reset.
- States:
  - IDLE: i_start=1 → RUN, stage=0, k=0.
  - RUN: one issue per cycle, k = 0..P/2-1; at k=P/2-1 → DRAIN.
  - DRAIN: exactly 3 cycles; then → RUN with stage+1 and k=0, or → DONE if stage = LOG2_PTS-1.
  - DONE: 1 cycle, o_done=1 → IDLE.
- Address generation, with s = stage, half = 2^s, pos = k mod half, grp = k >> s:
  - addr_a = grp·2^(s+1) + pos
  - addr_b = addr_a + half
  - tw = pos << (LOG2_PTS-1-s)
- Pipeline for an issue at cycle t:
  - t: o_rd_en=1 with addresses.
  - t+1: data captured into operand registers.
  - t+2: o_bf_valid=1 and operands stable.
  - t+3: o_wr_en=1; write data equals i_X/i_Y registered at t+2; addresses are the t addresses delayed 3 cycles.
- Drain guarantees the first read of stage s+1 occurs after the last write of stage s; no read-during-write hazard exists.
- o_busy = state ∈ {RUN, DRAIN}.
- Timing with i_start sampled at edge 0:
  - first issue at cycle 1; each stage takes P/2+3 cycles.
  - o_done at cycle LOG2_PTS·(P/2+3)+1.
  - For P=16: o_done at cycle 45, o_busy high cycles 1..44.
- i_start while not IDLE is ignored. i_start held high in DONE has no effect; a new run starts from IDLE on the next cycle it is sampled.
- o_stage updates when entering RUN for the next stage; it holds its value during DRAIN.
- No arithmetic is performed on data: operands and results pass through unchanged (scaling by 1/2 per stage is owned by the butterfly).
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset held, then released with random inputs → all outputs 0; i_rst_n low at cycle 20 of a run → outputs 0 that cycle, no o_wr_en thereafter, IDLE.
- P=16, start; log stage-0 reads → (a,b,tw) = (0,1,0),(2,3,0),(4,5,0)…(14,15,0) on cycles 1..8.
- Same run, stage 1 reads from cycle 12 → (0,2,0),(1,3,4),(4,6,0),(5,7,4)…; stage 3 → (0,8,0),(1,9,1)…(7,15,7).
- Butterfly model returns i_X = i_rd_Are+1, i_Y = i_rd_Bre+1 → each o_wr_en 3 cycles after its o_rd_en with the same addresses; no write of stage s after the first read of stage s+1.
- Full run with behavioural RAM, ROM and butterfly, impulse x[0]=0x4000 in bit-reversed order → all 16 outputs re=0x0400, im=0 (scaled by 1/16); o_done single pulse at cycle 45.
- i_start pulsed at cycles 5 and 44 → ignored, exactly one o_done; i_start high at cycle 46 → new run, first issue at cycle 47.

Source files
------------

// File: rtl/fft_iter_bf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_iter_bf_sequencer
// Purpose  : Stage/butterfly walker for an in-place radix-2 DIT FFT; issues
//            RAM/ROM reads, stages butterfly operands and writes results back.
// Revision : 1.0  initial release
// ============================================================================
module fft_iter_bf_sequencer #(
    parameter int N        = 16,
    parameter int LOG2_PTS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(LOG2_PTS):0]     o_stage,
    output logic                          o_rd_en,
    output logic [LOG2_PTS-1:0]           o_rd_addr_a,
    output logic [LOG2_PTS-1:0]           o_rd_addr_b,
    output logic [LOG2_PTS-2:0]           o_tw_addr,
    input  logic [N-1:0]                  i_rd_Are,
    input  logic [N-1:0]                  i_rd_Aim,
    input  logic [N-1:0]                  i_rd_Bre,
    input  logic [N-1:0]                  i_rd_Bim,
    input  logic [N-1:0]                  i_Wre,
    input  logic [N-1:0]                  i_Wim,
    output logic [N-1:0]                  o_Are,
    output logic [N-1:0]                  o_Aim,
    output logic [N-1:0]                  o_Bre,
    output logic [N-1:0]                  o_Bim,
    output logic [N-1:0]                  o_Wre,
    output logic [N-1:0]                  o_Wim,
    output logic                          o_bf_valid,
    input  logic [N-1:0]                  i_X_re,
    input  logic [N-1:0]                  i_X_im,
    input  logic [N-1:0]                  i_Y_re,
    input  logic [N-1:0]                  i_Y_im,
    output logic                          o_wr_en,
    output logic [LOG2_PTS-1:0]           o_wr_addr_a,
    output logic [LOG2_PTS-1:0]           o_wr_addr_b,
    output logic [N-1:0]                  o_wr_X_re,
    output logic [N-1:0]                  o_wr_X_im,
    output logic [N-1:0]                  o_wr_Y_re,
    output logic [N-1:0]                  o_wr_Y_im
);

    localparam int SW = $clog2(LOG2_PTS) + 1;
    localparam int KW = LOG2_PTS - 1;

    localparam logic [SW-1:0]       C_LAST_STAGE = SW'(LOG2_PTS - 1);
    localparam logic [SW-1:0]       C_STAGE_ONE  = SW'(1);
    localparam logic [KW-1:0]       C_LAST_K     = {KW{1'b1}};
    localparam logic [KW-1:0]       C_K_ONE      = KW'(1);
    localparam logic [LOG2_PTS-1:0] C_ONE        = LOG2_PTS'(1);
    localparam logic [1:0]          C_DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [KW-1:0]   r_k, w_k_nxt;
    logic [SW-1:0]   r_stage, w_stage_nxt;
    logic [1:0]      r_dcnt, w_dcnt_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_stage <= w_stage_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_stage_nxt = r_stage;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_k_nxt     = '0;
                    w_stage_nxt = '0;
                end
            end
            S_RUN: begin
                if (r_k == C_LAST_K) begin
                    w_state_nxt = S_DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_k_nxt = r_k + C_K_ONE;
                end
            end
            S_DRAIN: begin
                // Three drain cycles let the last write of this stage land
                // before the next stage reads.
                if (r_dcnt == C_DRAIN_LAST) begin
                    if (r_stage == C_LAST_STAGE) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_stage_nxt = r_stage + C_STAGE_ONE;
                        w_k_nxt     = '0;
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Addresses are derived from next-state counters so the read port is registered.
    logic                w_run_nxt;
    logic [LOG2_PTS-1:0] w_kx, w_mask, w_pos, w_addr_a, w_addr_b, w_tw_full;

    always_comb begin
        w_run_nxt = (w_state_nxt == S_RUN);
        w_kx      = {1'b0, w_k_nxt};
        w_mask    = (C_ONE << w_stage_nxt) - C_ONE;
        w_pos     = w_kx & w_mask;
        w_addr_a  = ((w_kx >> w_stage_nxt) << (w_stage_nxt + C_STAGE_ONE)) | w_pos;
        w_addr_b  = w_addr_a | (C_ONE << w_stage_nxt);
        w_tw_full = w_pos << (C_LAST_STAGE - w_stage_nxt);
    end

    logic                r_rd_vld;
    logic [LOG2_PTS-1:0] r_addr_a_d1, r_addr_b_d1, r_addr_a_d2, r_addr_b_d2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_stage     <= '0;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_addr   <= '0;
        end else begin
            o_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            o_done      <= (w_state_nxt == S_DONE);
            o_stage     <= w_stage_nxt;
            o_rd_en     <= w_run_nxt;
            o_rd_addr_a <= w_run_nxt ? w_addr_a : '0;
            o_rd_addr_b <= w_run_nxt ? w_addr_b : '0;
            o_tw_addr   <= w_run_nxt ? w_tw_full[KW-1:0] : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_vld    <= 1'b0;
            r_addr_a_d1 <= '0;
            r_addr_b_d1 <= '0;
            r_addr_a_d2 <= '0;
            r_addr_b_d2 <= '0;
            o_bf_valid  <= 1'b0;
            o_Are       <= '0;
            o_Aim       <= '0;
            o_Bre       <= '0;
            o_Bim       <= '0;
            o_Wre       <= '0;
            o_Wim       <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr_a <= '0;
            o_wr_addr_b <= '0;
            o_wr_X_re   <= '0;
            o_wr_X_im   <= '0;
            o_wr_Y_re   <= '0;
            o_wr_Y_im   <= '0;
        end else begin
            r_rd_vld    <= o_rd_en;
            r_addr_a_d1 <= o_rd_addr_a;
            r_addr_b_d1 <= o_rd_addr_b;
            o_bf_valid  <= r_rd_vld;
            r_addr_a_d2 <= r_addr_a_d1;
            r_addr_b_d2 <= r_addr_b_d1;
            if (r_rd_vld) begin
                o_Are <= i_rd_Are;
                o_Aim <= i_rd_Aim;
                o_Bre <= i_rd_Bre;
                o_Bim <= i_rd_Bim;
                o_Wre <= i_Wre;
                o_Wim <= i_Wim;
            end
            o_wr_en     <= o_bf_valid;
            o_wr_addr_a <= r_addr_a_d2;
            o_wr_addr_b <= r_addr_b_d2;
            if (o_bf_valid) begin
                o_wr_X_re <= i_X_re;
                o_wr_X_im <= i_X_im;
                o_wr_Y_re <= i_Y_re;
                o_wr_Y_im <= i_Y_im;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_iter_bf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_iter_bf_sequencer
// Purpose  : Directed bench for the FFT butterfly sequencer (P = 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_iter_bf_sequencer;

    localparam int N  = 16;
    localparam int L  = 4;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, rd_en, bf_valid, wr_en;
    logic [SW-1:0] stage;
    logic [L-1:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [L-2:0]  tw_addr;
    logic [N-1:0]  rd_Are, rd_Aim, rd_Bre, rd_Bim, Wre, Wim;
    logic [N-1:0]  Are, Aim, Bre, Bim, oWre, oWim;
    logic [N-1:0]  X_re, X_im, Y_re, Y_im;
    logic [N-1:0]  wr_X_re, wr_X_im, wr_Y_re, wr_Y_im;

    int checks = 0;
    int errors = 0;

    bit mode_inc = 1'b0;
    bit rand_en  = 1'b0;
    bit load_req = 1'b0;

    logic [N-1:0] mem_re [16];
    logic [N-1:0] mem_im [16];
    logic [N-1:0] rom_re [8] = '{16'h7FFF, 16'h7641, 16'h5A82, 16'h30FB,
                                 16'h0000, 16'hCF05, 16'hA57E, 16'h89BF};
    logic [N-1:0] rom_im [8] = '{16'h0000, 16'hCF05, 16'hA57E, 16'h89BF,
                                 16'h8001, 16'h89BF, 16'hA57E, 16'hCF05};
    logic [N-1:0] rnd_xr, rnd_xi, rnd_yr, rnd_yi;

    // Hand-derived read schedule for P = 16, indexed [stage][k].
    int a_tab  [4][8] = '{'{0, 2, 4, 6, 8, 10, 12, 14},
                          '{0, 1, 4, 5, 8,  9, 12, 13},
                          '{0, 1, 2, 3, 8,  9, 10, 11},
                          '{0, 1, 2, 3, 4,  5,  6,  7}};
    int tw_tab [4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                          '{0, 4, 0, 4, 0, 4, 0, 4},
                          '{0, 2, 4, 6, 0, 2, 4, 6},
                          '{0, 1, 2, 3, 4, 5, 6, 7}};
    int half_tab [4] = '{1, 2, 4, 8};

    always #5 clk = ~clk;

    fft_iter_bf_sequencer #(.N(N), .LOG2_PTS(L)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_stage(stage),
        .o_rd_en(rd_en), .o_rd_addr_a(rd_addr_a), .o_rd_addr_b(rd_addr_b),
        .o_tw_addr(tw_addr),
        .i_rd_Are(rd_Are), .i_rd_Aim(rd_Aim), .i_rd_Bre(rd_Bre), .i_rd_Bim(rd_Bim),
        .i_Wre(Wre), .i_Wim(Wim),
        .o_Are(Are), .o_Aim(Aim), .o_Bre(Bre), .o_Bim(Bim), .o_Wre(oWre), .o_Wim(oWim),
        .o_bf_valid(bf_valid),
        .i_X_re(X_re), .i_X_im(X_im), .i_Y_re(Y_re), .i_Y_im(Y_im),
        .o_wr_en(wr_en), .o_wr_addr_a(wr_addr_a), .o_wr_addr_b(wr_addr_b),
        .o_wr_X_re(wr_X_re), .o_wr_X_im(wr_X_im), .o_wr_Y_re(wr_Y_re), .o_wr_Y_im(wr_Y_im)
    );

    logic outs_or;
    assign outs_or = |{busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                       Are, Aim, Bre, Bim, oWre, oWim, bf_valid, wr_en,
                       wr_addr_a, wr_addr_b, wr_X_re, wr_X_im, wr_Y_re, wr_Y_im};

    // RAM / ROM model with one-cycle read latency.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
            mem_re[0] <= 16'h4000;
        end
        if (rand_en) begin
            rd_Are <= N'($urandom); rd_Aim <= N'($urandom);
            rd_Bre <= N'($urandom); rd_Bim <= N'($urandom);
            Wre    <= N'($urandom); Wim    <= N'($urandom);
            rnd_xr <= N'($urandom); rnd_xi <= N'($urandom);
            rnd_yr <= N'($urandom); rnd_yi <= N'($urandom);
        end else if (rd_en) begin
            if (mode_inc) begin
                rd_Are <= {12'h000, rd_addr_a};
                rd_Aim <= 16'h0100 + {12'h000, rd_addr_a};
                rd_Bre <= 16'h0200 + {12'h000, rd_addr_b};
                rd_Bim <= 16'h0300 + {12'h000, rd_addr_b};
                Wre    <= 16'h0400 + {13'h0000, tw_addr};
                Wim    <= 16'h0500 + {13'h0000, tw_addr};
            end else begin
                rd_Are <= mem_re[rd_addr_a];
                rd_Aim <= mem_im[rd_addr_a];
                rd_Bre <= mem_re[rd_addr_b];
                rd_Bim <= mem_im[rd_addr_b];
                Wre    <= rom_re[tw_addr];
                Wim    <= rom_im[tw_addr];
            end
        end
        if (wr_en && !mode_inc && !rand_en && !load_req) begin
            mem_re[wr_addr_a] <= wr_X_re;
            mem_im[wr_addr_a] <= wr_X_im;
            mem_re[wr_addr_b] <= wr_Y_re;
            mem_im[wr_addr_b] <= wr_Y_im;
        end
    end

    // Butterfly model: X = (A + W*B)/2, Y = (A - W*B)/2.
    int wb_re, wb_im, a_re, a_im;
    always_comb begin
        wb_re = (int'($signed(oWre)) * int'($signed(Bre)) - int'($signed(oWim)) * int'($signed(Bim))) >>> 15;
        wb_im = (int'($signed(oWre)) * int'($signed(Bim)) + int'($signed(oWim)) * int'($signed(Bre))) >>> 15;
        a_re  = int'($signed(Are));
        a_im  = int'($signed(Aim));
        if (rand_en) begin
            X_re = rnd_xr; X_im = rnd_xi; Y_re = rnd_yr; Y_im = rnd_yi;
        end else if (mode_inc) begin
            X_re = Are + 16'd1; X_im = Aim; Y_re = Bre + 16'd1; Y_im = Bim;
        end else begin
            X_re = N'((a_re + wb_re) >>> 1);
            X_im = N'((a_im + wb_im) >>> 1);
            Y_re = N'((a_re - wb_re) >>> 1);
            Y_im = N'((a_im - wb_im) >>> 1);
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses start so that it is sampled at the next edge ("edge 0").
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rand_en = 1'b1;
        rst_n   = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs_or !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d outputs_or=%b exp 0", i, outs_or);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs_or !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cyc=%0d outputs_or=%b exp 0", i, outs_or);
            end
        end
        rand_en = 1'b0;
    endtask

    task automatic test_addr_pipeline();
        int s, w, cw, cb, ws, wk, ea, eb;
        int rd_seen, wr_seen;
        int first_rd [4];
        int last_wr  [4];
        logic exp_rd, exp_wr, exp_bf;
        mode_inc = 1'b1;
        reset_dut();
        rd_seen = 0;
        wr_seen = 0;
        kick();
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            s = (c - 1) / 11;
            w = (c - 1) % 11;
            exp_rd = (c <= 44) && (w < 8);
            checks++;
            if (rd_en !== exp_rd || busy !== (c <= 44) || done !== (c == 45) ||
                stage !== SW'((c <= 44) ? s : 3)) begin
                errors++;
                $display("FAIL ctrl c=%0d got rd_en=%b busy=%b done=%b stage=%0d exp %b %b %b %0d",
                         c, rd_en, busy, done, stage, exp_rd, c <= 44, c == 45, (c <= 44) ? s : 3);
            end
            if (exp_rd) begin
                ea = a_tab[s][w];
                eb = ea + half_tab[s];
                checks++;
                if (rd_addr_a !== L'(ea) || rd_addr_b !== L'(eb) || tw_addr !== 3'(tw_tab[s][w])) begin
                    errors++;
                    $display("FAIL rd_addr c=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d",
                             c, rd_addr_a, rd_addr_b, tw_addr, ea, eb, tw_tab[s][w]);
                end
            end
            cb = c - 2;
            exp_bf = (cb >= 1) && (cb <= 44) && (((cb - 1) % 11) < 8);
            checks++;
            if (bf_valid !== exp_bf) begin
                errors++;
                $display("FAIL bf_valid c=%0d got %b exp %b", c, bf_valid, exp_bf);
            end else if (exp_bf) begin
                ws = (cb - 1) / 11;
                wk = (cb - 1) % 11;
                checks++;
                if (Are !== 16'(a_tab[ws][wk]) || oWre !== 16'(16'h0400 + tw_tab[ws][wk])) begin
                    errors++;
                    $display("FAIL operands c=%0d got Are=%h Wre=%h exp %h %h",
                             c, Are, oWre, a_tab[ws][wk], 16'h0400 + tw_tab[ws][wk]);
                end
            end
            cw = c - 3;
            exp_wr = (cw >= 1) && (cw <= 44) && (((cw - 1) % 11) < 8);
            checks++;
            if (wr_en !== exp_wr) begin
                errors++;
                $display("FAIL wr_en c=%0d got %b exp %b", c, wr_en, exp_wr);
            end else if (exp_wr) begin
                ws = (cw - 1) / 11;
                wk = (cw - 1) % 11;
                ea = a_tab[ws][wk];
                eb = ea + half_tab[ws];
                checks++;
                if (wr_addr_a !== L'(ea) || wr_addr_b !== L'(eb) ||
                    wr_X_re !== 16'(ea + 1) || wr_X_im !== 16'(16'h0100 + ea) ||
                    wr_Y_re !== 16'(16'h0201 + eb) || wr_Y_im !== 16'(16'h0300 + eb)) begin
                    errors++;
                    $display("FAIL wr_data c=%0d got a=%0d b=%0d X=%h/%h Y=%h/%h exp a=%0d b=%0d",
                             c, wr_addr_a, wr_addr_b, wr_X_re, wr_X_im, wr_Y_re, wr_Y_im, ea, eb);
                end
            end
            if (rd_en === 1'b1) begin
                if (rd_seen % 8 == 0 && rd_seen < 32) first_rd[rd_seen / 8] = c;
                rd_seen++;
            end
            if (wr_en === 1'b1) begin
                if (wr_seen < 32) last_wr[wr_seen / 8] = c;
                wr_seen++;
            end
        end
        checks++;
        if (rd_seen != 32 || wr_seen != 32) begin
            errors++;
            $display("FAIL txn_count got rd=%0d wr=%0d exp 32 32", rd_seen, wr_seen);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (last_wr[i] >= first_rd[i + 1]) begin
                    errors++;
                    $display("FAIL hazard stage=%0d last_wr=%0d next_first_rd=%0d",
                             i, last_wr[i], first_rd[i + 1]);
                end
            end
        end
        mode_inc = 1'b0;
    endtask

    task automatic test_impulse();
        int done_cnt, done_cyc;
        mode_inc = 1'b0;
        reset_dut();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
        kick();
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 45) begin
            errors++;
            $display("FAIL impulse_done got count=%0d cycle=%0d exp 1 45", done_cnt, done_cyc);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem_re[i] !== 16'h0400 || mem_im[i] !== 16'h0000) begin
                errors++;
                $display("FAIL impulse_bin%0d got re=%h im=%h exp 0400 0000", i, mem_re[i], mem_im[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int done_cnt, done_cyc, new_rd;
        mode_inc = 1'b1;
        reset_dut();
        done_cnt = 0;
        done_cyc = -1;
        new_rd   = -1;
        kick();
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c > 45 && rd_en === 1'b1 && new_rd < 0) new_rd = c;
            if (c == 46) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_gap c=46 busy=%b exp 0", busy);
                end
            end
            start = (c == 5) || (c == 44) || (c == 45) || (c == 46);
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 1 || done_cyc != 45) begin
            errors++;
            $display("FAIL ignore_start_done got count=%0d cycle=%0d exp 1 45", done_cnt, done_cyc);
        end
        checks++;
        if (new_rd != 47) begin
            errors++;
            $display("FAIL restart_issue got first_rd=%0d exp 47", new_rd);
        end
        mode_inc = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int wr_after, busy_after;
        mode_inc = 1'b1;
        reset_dut();
        kick();
        for (int c = 1; c < 20; c++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_or !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset outputs_or=%b exp 0", outs_or);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_after   = 0;
        busy_after = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (wr_en !== 1'b0) wr_after++;
            if (busy !== 1'b0) busy_after++;
        end
        checks++;
        if (wr_after != 0 || busy_after != 0) begin
            errors++;
            $display("FAIL post_reset got wr_cycles=%0d busy_cycles=%0d exp 0 0", wr_after, busy_after);
        end
        mode_inc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_addr_pipeline();
        test_impulse();
        test_start_ignored();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
